simon_ctrl: RTL and testbench

Sequencing controller for the iterative SIMON round datapath. It sits between the packet input stage (SIMON_dataIN2-style) and the round/key-schedule core, and takes key and data requests from the input stage. It drives the load handshakes and the key-schedule and round enables, counts rounds, and presents results to a downstream consumer. Key requests take priority, and data is accepted only once a valid key has been loaded.

---
 rtl/simon_pkg.sv | 50 +++++
 rtl/simon_rnd_cnt.sv | 40 ++++
 rtl/simon_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_simon_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON sequencing controller and its round core.
package simon_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KLOAD = 3'd1,
        S_KEXP  = 3'd2,
        S_DLOAD = 3'd3,
        S_ROUND = 3'd4,
        S_OUT   = 3'd5
    } simon_state_e;

    localparam int MODE_ENC = 0;
    localparam int MODE_DEC = 1;

    // z-sequences written first bit on the left, so bit j lives at [61-j].
    localparam logic [61:0] SIMON_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] SIMON_Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] SIMON_Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] SIMON_Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] SIMON_Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    // Round count for a word size n and key-word count m; 0 for unlisted pairs.
    function automatic int simon_rounds(input int n, input int m);
        int r;
        r = 0;
        case (n)
            16:      r = 32;
            24:      r = 36;
            32:      r = (m == 3) ? 42 : 44;
            48:      r = (m == 2) ? 52 : 54;
            64:      r = (m == 2) ? 68 : ((m == 3) ? 69 : 72);
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic simon_z_bit(input int seq, input int idx);
        logic [61:0] z;
        case (seq)
            0:       z = SIMON_Z0;
            1:       z = SIMON_Z1;
            2:       z = SIMON_Z2;
            3:       z = SIMON_Z3;
            default: z = SIMON_Z4;
        endcase
        return z[61 - (idx % 62)];
    endfunction

endpackage

// File: rtl/simon_rnd_cnt.sv
// Round/key index register: preset-able up/down counter with a terminal-match flag.
module simon_rnd_cnt #(
    parameter int Cb = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ld_i,
    input  logic [Cb-1:0] ld_val_i,
    input  logic          en_i,
    input  logic          up_i,
    input  logic [Cb-1:0] term_i,
    output logic [Cb-1:0] cnt_o,
    output logic          at_term_o
);

    logic [Cb-1:0] cnt_q;
    logic [Cb-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = up_i ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare-based terminal detect keeps T == 2**Cb legal.
    assign cnt_o     = cnt_q;
    assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/simon_ctrl.sv
// Sequencing FSM for the iterative SIMON core: key/data load handshakes,
// key-schedule and round enables, round indexing and result hand-off.
module simon_ctrl
    import simon_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = simon_rounds(N, M),
    parameter int Cb   = 5,
    parameter int MODE = MODE_ENC
) (
    input  logic          clk,
    input  logic          R,
    input  logic          newKey,
    input  logic          newData,
    output logic          loadKey,
    output logic          loadData,
    output logic          doneKey,
    output logic          doneData,
    output logic          keyLd,
    output logic          keyEn,
    output logic          blkLd,
    output logic          rndEn,
    output logic [Cb-1:0] rnd,
    output logic          outValid,
    input  logic          outReady,
    output logic          keyValid,
    output logic          busy
);

    localparam logic [Cb-1:0] RND_LAST = Cb'(T - 1);
    localparam logic [Cb-1:0] RND_KEY0 = Cb'(M);
    localparam logic [Cb-1:0] KEY_FROM = Cb'(M - 1);

    simon_state_e  state_q, state_d;
    logic          ph_q, ph_d;
    logic          key_valid_q, key_valid_d;
    logic          done_key_q, done_key_d;
    logic          done_data_q, done_data_d;

    logic          cnt_ld;
    logic [Cb-1:0] cnt_val;
    logic          cnt_en;
    logic          cnt_up;
    logic [Cb-1:0] cnt_term;
    logic          cnt_at_term;

    simon_rnd_cnt #(
        .Cb(Cb)
    ) u_rnd_cnt (
        .clk_i    (clk),
        .rst_i    (R),
        .ld_i     (cnt_ld),
        .ld_val_i (cnt_val),
        .en_i     (cnt_en),
        .up_i     (cnt_up),
        .term_i   (cnt_term),
        .cnt_o    (rnd),
        .at_term_o(cnt_at_term)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            state_q     <= S_IDLE;
            ph_q        <= 1'b0;
            key_valid_q <= 1'b0;
            done_key_q  <= 1'b0;
            done_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            key_valid_q <= key_valid_d;
            done_key_q  <= done_key_d;
            done_data_q <= done_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = 1'b0;
        key_valid_d = key_valid_q;
        done_key_d  = 1'b0;
        done_data_d = 1'b0;
        cnt_ld      = 1'b0;
        cnt_val     = '0;
        cnt_en      = 1'b0;
        cnt_up      = 1'b1;
        cnt_term    = RND_LAST;
        case (state_q)
            S_IDLE: begin
                // Requests are level-held until their done pulse, so a request
                // seen alongside its own done pulse is the one just finished.
                if (newKey && !done_key_q) begin
                    state_d     = S_KLOAD;
                    key_valid_d = 1'b0;
                end else if (newData && key_valid_q && !done_data_q) begin
                    state_d = S_DLOAD;
                    cnt_ld  = 1'b1;
                    cnt_val = (MODE == MODE_DEC) ? RND_LAST : '0;
                end
            end
            S_KLOAD: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (MODE == MODE_DEC) begin
                        state_d = S_KEXP;
                        cnt_ld  = 1'b1;
                        cnt_val = RND_KEY0;
                    end else begin
                        state_d     = S_IDLE;
                        done_key_d  = 1'b1;
                        key_valid_d = 1'b1;
                    end
                end
            end
            S_KEXP: begin
                cnt_en = 1'b1;
                if (cnt_at_term) begin
                    state_d     = S_IDLE;
                    done_key_d  = 1'b1;
                    key_valid_d = 1'b1;
                    cnt_ld      = 1'b1;
                end
            end
            S_DLOAD: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                cnt_en   = 1'b1;
                cnt_up   = (MODE != MODE_DEC);
                cnt_term = (MODE == MODE_DEC) ? '0 : RND_LAST;
                if (cnt_at_term) begin
                    state_d = S_OUT;
                    cnt_ld  = 1'b1;
                end
            end
            S_OUT: begin
                if (outReady) begin
                    state_d     = S_IDLE;
                    done_data_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        loadKey  = 1'b0;
        loadData = 1'b0;
        keyLd    = 1'b0;
        keyEn    = 1'b0;
        blkLd    = 1'b0;
        rndEn    = 1'b0;
        outValid = 1'b0;
        doneKey  = done_key_q;
        doneData = done_data_q;
        keyValid = key_valid_q;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_KLOAD: begin
                loadKey = 1'b1;
                keyLd   = ph_q;
            end
            S_KEXP: begin
                keyEn = 1'b1;
            end
            S_DLOAD: begin
                loadData = 1'b1;
                blkLd    = ph_q;
            end
            S_ROUND: begin
                rndEn = 1'b1;
                // On-the-fly schedule only produces new words past the first M.
                keyEn = (MODE == MODE_ENC) && (rnd >= KEY_FROM);
            end
            S_OUT: begin
                outValid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simon_ctrl.sv
// Bench for simon_ctrl: vector table, timeline reference model under random
// request traffic, and directed multi-cycle sequences for both modes.
module tb_simon_ctrl;

    localparam int TR = 32;
    localparam int MK = 4;

    localparam logic [10:0] LK = 11'h400;
    localparam logic [10:0] LD = 11'h200;
    localparam logic [10:0] DK = 11'h100;
    localparam logic [10:0] DD = 11'h080;
    localparam logic [10:0] KL = 11'h040;
    localparam logic [10:0] KE = 11'h020;
    localparam logic [10:0] BL = 11'h010;
    localparam logic [10:0] RE = 11'h008;
    localparam logic [10:0] OV = 11'h004;
    localparam logic [10:0] KV = 11'h002;
    localparam logic [10:0] BZ = 11'h001;
    localparam logic [10:0] Z0 = 11'h000;

    typedef struct {
        logic        r, nk, nd, ordy;
        logic [10:0] o;
        logic [4:0]  rnd;
    } vec_t;

    typedef struct {
        logic [10:0] o;
        logic [4:0]  rnd;
        bit          chk, fk, fd;
    } rec_t;

    logic       clk;
    logic       R0, nk0, nd0, or0, R1, nk1, nd1, or1;
    logic       lk0, ld0, dk0, dd0, kl0, ke0, bl0, re0, ov0, kv0, bz0;
    logic       lk1, ld1, dk1, dd1, kl1, ke1, bl1, re1, ov1, kv1, bz1;
    logic [4:0] rnd0, rnd1;
    logic [10:0] o0, o1;

    int   nvec, nmis, cyc, nre, nke, last_ke;
    bit   found, lk_seen, m_kv, m_pdk, m_pdd, m_out, pv_dk, pv_dd;
    vec_t tbl[17];
    rec_t e;
    rec_t plan[$];

    assign o0 = {lk0, ld0, dk0, dd0, kl0, ke0, bl0, re0, ov0, kv0, bz0};
    assign o1 = {lk1, ld1, dk1, dd1, kl1, ke1, bl1, re1, ov1, kv1, bz1};

    simon_ctrl #(.N(16), .M(MK), .T(TR), .Cb(5), .MODE(0)) dut0 (
        .clk(clk), .R(R0), .newKey(nk0), .newData(nd0), .loadKey(lk0), .loadData(ld0),
        .doneKey(dk0), .doneData(dd0), .keyLd(kl0), .keyEn(ke0), .blkLd(bl0), .rndEn(re0),
        .rnd(rnd0), .outValid(ov0), .outReady(or0), .keyValid(kv0), .busy(bz0));

    simon_ctrl #(.N(16), .M(MK), .T(TR), .Cb(5), .MODE(1)) dut1 (
        .clk(clk), .R(R1), .newKey(nk1), .newData(nd1), .loadKey(lk1), .loadData(ld1),
        .doneKey(dk1), .doneData(dd1), .keyLd(kl1), .keyEn(ke1), .blkLd(bl1), .rndEn(re1),
        .rnd(rnd1), .outValid(ov1), .outReady(or1), .keyValid(kv1), .busy(bz1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [10:0] o, input logic [4:0] r, input bit c,
                                input bit fk, input bit fd);
        rec_t x;
        x.o = o; x.rnd = r; x.chk = c; x.fk = fk; x.fd = fd;
        return x;
    endfunction

    initial begin
        nvec = 0; nmis = 0;
        R0 = 1'b1; nk0 = 1'b0; nd0 = 1'b0; or0 = 1'b0;
        R1 = 1'b1; nk1 = 1'b0; nd1 = 1'b0; or1 = 1'b0;

        // {R, newKey, newData, outReady, expected outputs, expected rnd}
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, Z0,                5'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, Z0,                5'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, Z0,                5'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, LK | BZ,           5'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, LK | KL | BZ,      5'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, DK | KV,           5'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, KV,                5'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, KV,                5'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, LK | BZ,           5'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, LK | KL | BZ,      5'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, DK | KV,           5'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, LD | BZ | KV,      5'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, LD | BL | BZ | KV, 5'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, RE | BZ | KV,      5'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, RE | BZ | KV,      5'd1};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, Z0,                5'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, Z0,                5'd0};

        tick(); tick();
        for (int i = 0; i < 17; i++) begin
            R0 = tbl[i].r; nk0 = tbl[i].nk; nd0 = tbl[i].nd; or0 = tbl[i].ordy;
            nvec++;
            if (o0 !== tbl[i].o || rnd0 !== tbl[i].rnd) begin
                nmis++;
                $display("FAIL vec%0d: got o=%b rnd=%0d, required o=%b rnd=%0d",
                         i, o0, rnd0, tbl[i].o, tbl[i].rnd);
            end
            tick();
        end

        // No key loaded: a data request alone must not start anything.
        for (int i = 0; i < 10; i++) begin
            nd0 = 1'b1;
            chk("idle_no_key", {30'd0, ld0, bz0}, 32'd0);
            tick();
        end

        // Random request traffic against a timeline model of the operations.
        m_kv = 1'b0; m_pdk = 1'b0; m_pdd = 1'b0; m_out = 1'b0;
        pv_dk = 1'b0; pv_dd = 1'b0; nk0 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (nk0 && pv_dk) nk0 = 1'b0;
            else if (!nk0 && $urandom_range(0, 24) == 0) nk0 = 1'b1;
            if (nd0 && pv_dd) nd0 = 1'b0;
            else if (!nd0 && $urandom_range(0, 4) == 0) nd0 = 1'b1;
            or0 = ($urandom_range(0, 2) == 0);

            if (plan.size() > 0) begin
                e = plan.pop_front();
                if (e.fk) begin m_kv = 1'b1; m_pdk = 1'b1; end
                if (e.fd) m_out = 1'b1;
            end else if (m_out) begin
                e = mk(OV | BZ | (m_kv ? KV : Z0), 5'd0, 1'b0, 1'b0, 1'b0);
                if (or0) begin m_out = 1'b0; m_pdd = 1'b1; end
            end else begin
                e = mk((m_kv ? KV : Z0) | (m_pdk ? DK : Z0) | (m_pdd ? DD : Z0),
                       5'd0, 1'b0, 1'b0, 1'b0);
                if (nk0 && !m_pdk) begin
                    m_kv = 1'b0;
                    plan.push_back(mk(LK | BZ, 5'd0, 1'b0, 1'b0, 1'b0));
                    plan.push_back(mk(LK | KL | BZ, 5'd0, 1'b0, 1'b1, 1'b0));
                end else if (nd0 && m_kv && !m_pdd) begin
                    plan.push_back(mk(LD | BZ | KV, 5'd0, 1'b0, 1'b0, 1'b0));
                    plan.push_back(mk(LD | BL | BZ | KV, 5'd0, 1'b0, 1'b0, 1'b0));
                    for (int r = 0; r < TR; r++)
                        plan.push_back(mk(RE | BZ | KV | ((r >= MK - 1) ? KE : Z0),
                                          5'(r), 1'b1, 1'b0, (r == TR - 1)));
                end
                m_pdk = 1'b0; m_pdd = 1'b0;
            end

            nvec++;
            if (o0 !== e.o || (e.chk && rnd0 !== e.rnd)) begin
                nmis++;
                $display("FAIL rand cyc%0d: got o=%b rnd=%0d, required o=%b rnd=%0d",
                         c, o0, rnd0, e.o, e.rnd);
            end
            pv_dk = dk0; pv_dd = dd0;
            tick();
        end

        // Encrypt data run: latency, round indexing, deferred key, backpressure.
        R0 = 1'b1; nk0 = 1'b0; nd0 = 1'b0; or0 = 1'b0;
        tick(); tick();
        R0 = 1'b0; nk0 = 1'b1; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); if (dk0) found = 1'b1; end
        chk("m0_key_done", {31'd0, found}, 32'd1);
        chk("m0_key_valid", {31'd0, kv0}, 32'd1);
        nk0 = 1'b0;
        tick();
        nd0 = 1'b1; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); if (ld0) found = 1'b1; end
        chk("m0_dload_seen", {31'd0, found}, 32'd1);
        cyc = 0; nre = 0; nke = 0; lk_seen = 1'b0; found = 1'b0;
        while (!found && cyc < 60) begin
            if (re0) begin chk("m0_rnd_up", {27'd0, rnd0}, nre); nre++; end
            if (ke0) nke++;
            if (lk0) lk_seen = 1'b1;
            if (ov0) found = 1'b1;
            else begin tick(); cyc++; if (cyc == 2) nk0 = 1'b1; end
        end
        chk("m0_out_latency", cyc, TR + 2);
        chk("m0_rndEn_count", nre, TR);
        chk("m0_keyEn_count", nke, TR - MK + 1);
        chk("m0_key_deferred", {31'd0, lk_seen}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("m0_backpressure", {28'd0, ov0, dd0, bz0, lk0}, 32'b1010);
            tick();
        end
        chk("m0_bp_end", {29'd0, ov0, dd0, bz0}, 32'b101);
        or0 = 1'b1;
        tick();
        or0 = 1'b0;
        chk("m0_done_data", {28'd0, dd0, ov0, bz0, lk0}, 32'b1000);
        nd0 = 1'b0;
        tick();
        chk("m0_done_once_key_next", {30'd0, dd0, lk0}, 32'b01);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); if (dk0) found = 1'b1; end
        chk("m0_deferred_key_done", {31'd0, found}, 32'd1);
        nk0 = 1'b0;

        // Decrypt mode: key expansion then reverse round order.
        R1 = 1'b1;
        tick(); tick();
        R1 = 1'b0;
        chk("m1_reset", {16'd0, o1, rnd1}, 32'd0);
        nk1 = 1'b1; found = 1'b0; nke = 0; last_ke = -1; cyc = 0;
        while (!found && cyc < 80) begin
            tick(); cyc++;
            if (ke1) begin chk("m1_kexp_rnd", {27'd0, rnd1}, MK + nke); nke++; last_ke = cyc; end
            if (dk1) found = 1'b1;
        end
        chk("m1_kexp_count", nke, TR - MK);
        chk("m1_donekey_gap", cyc - last_ke, 1);
        chk("m1_key_valid", {31'd0, kv1}, 32'd1);
        nk1 = 1'b0;
        tick();
        nd1 = 1'b1; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); if (ld1) found = 1'b1; end
        chk("m1_dload_seen", {31'd0, found}, 32'd1);
        cyc = 0; nre = 0; found = 1'b0;
        while (!found && cyc < 60) begin
            if (re1) begin chk("m1_rnd_down", {27'd0, rnd1}, TR - 1 - nre); nre++; end
            if (ov1) found = 1'b1;
            else begin tick(); cyc++; end
        end
        chk("m1_out_latency", cyc, TR + 2);
        chk("m1_rndEn_count", nre, TR);
        chk("m1_rnd_held", {27'd0, rnd1}, 32'd0);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        chk("m1_done_data", {29'd0, dd1, ov1, bz1}, 32'b100);
        nd1 = 1'b0;
        tick();
        chk("m1_done_pulse", {31'd0, dd1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
